// File: rtl/act_skew_feeder.sv
// ---------------------------------------------------------------------------
// act_skew_feeder
//
// Feeds activation vectors into the row inputs of a systolic array with the
// diagonal skew the array needs: row r of a vector accepted in cycle t
// appears on a_row row r in cycle t+1+r. Alongside the data it sequences
// the job (stream, flush the skew, optional output-stationary drain) and
// broadcasts the PE operation code.
//
// Parameters
//   ROWS          number of array rows fed (2..16)
//   ACT_WIDTH     activation width per row
//   OP_SIG_WIDTH  PE operation code width
//   DRAIN_CYCLES  output-stationary drain length in cycles (1..255)
//
// Ports
//   clk        clock, all state on rising edge
//   reset      asynchronous, active-high reset
//   start      single-cycle job start (honoured only in IDLE)
//   mode       sampled at start: 0 = weight-stationary, 1 = output-stationary
//   vec_valid  activation vector valid
//   vec_data   activation vector, row r at [r*ACT_WIDTH +: ACT_WIDTH]
//   vec_last   final vector of the job, qualified by vec_valid
//   vec_ready  vector accepted this cycle when vec_valid is also high
//   a_row      skewed activations, same packing as vec_data
//   op_sig     broadcast PE operation code (registered)
//   busy       high whenever the FSM is not IDLE
//   done       one-cycle pulse in the cycle after the DONE state
//   vec_count  (only with ACT_SKEW_FEEDER_COUNT_EN) vectors accepted in the
//              current job, saturating at 16'hFFFF
//
// Build option: define ACT_SKEW_FEEDER_COUNT_EN to add vec_count.
// ---------------------------------------------------------------------------
module act_skew_feeder #(
    parameter int ROWS         = 4,
    parameter int ACT_WIDTH    = 8,
    parameter int OP_SIG_WIDTH = 3,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      mode,
    input  logic                      vec_valid,
    input  logic [ROWS*ACT_WIDTH-1:0] vec_data,
    input  logic                      vec_last,
    output logic                      vec_ready,
    output logic [ROWS*ACT_WIDTH-1:0] a_row,
    output logic [OP_SIG_WIDTH-1:0]   op_sig,
    output logic                      busy,
    output logic                      done
`ifdef ACT_SKEW_FEEDER_COUNT_EN
    ,
    output logic [15:0]               vec_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [OP_SIG_WIDTH-1:0] OP_WS    = OP_SIG_WIDTH'(3'b000);
    localparam logic [OP_SIG_WIDTH-1:0] OP_OS    = OP_SIG_WIDTH'(3'b100);
    localparam logic [OP_SIG_WIDTH-1:0] OP_DRAIN = OP_SIG_WIDTH'(3'b110);
    localparam logic [OP_SIG_WIDTH-1:0] OP_HOLD  = OP_SIG_WIDTH'(3'b111);

    // Terminal counts: FLUSH lasts ROWS-1 cycles, DRAIN lasts DRAIN_CYCLES.
    localparam logic [7:0] FLUSH_LAST = 8'(ROWS - 2);
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

    state_t                    r_state;
    logic                      r_mode;
    logic [7:0]                r_cnt;
    logic [OP_SIG_WIDTH-1:0]   r_op;
    logic                      r_done;
    logic                      w_accept;
    logic [ROWS*ACT_WIDTH-1:0] w_inject;

    function automatic logic [OP_SIG_WIDTH-1:0] op_for(input state_t s, input logic m);
        case (s)
            S_STREAM, S_FLUSH: return m ? OP_OS : OP_WS;
            S_DRAIN:           return OP_DRAIN;
            default:           return OP_HOLD;
        endcase
    endfunction

    assign vec_ready = (r_state == S_STREAM);
    assign w_accept  = vec_valid & vec_ready;
    // Zeros enter the skew lines whenever nothing is accepted, so bubbles and
    // the flush tail never replay stale activations.
    assign w_inject  = w_accept ? vec_data : '0;
    assign busy      = (r_state != S_IDLE);
    assign op_sig    = r_op;
    assign done      = r_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_cnt   <= 8'd0;
            r_op    <= OP_HOLD;
            r_done  <= 1'b0;
        end else begin
            // op_sig and done reflect the state of the previous cycle.
            r_op   <= op_for(r_state, r_mode);
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_STREAM;
                        r_mode  <= mode;
                        r_cnt   <= 8'd0;
                    end
                end
                S_STREAM: begin
                    if (w_accept && vec_last) begin
                        r_state <= S_FLUSH;
                        r_cnt   <= 8'd0;
                    end
                end
                S_FLUSH: begin
                    if (r_cnt == FLUSH_LAST) begin
                        r_cnt   <= 8'd0;
                        r_state <= r_mode ? S_DRAIN : S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == DRAIN_LAST) begin
                        r_cnt   <= 8'd0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Per-row skew line: row r holds r+1 stages packed into one vector,
    // newest at the bottom, oldest (the output) at the top.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        logic [(gr+1)*ACT_WIDTH-1:0] r_dly;

        if (gr == 0) begin : g_first
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_dly <= '0;
                else       r_dly <= w_inject[0 +: ACT_WIDTH];
            end
        end else begin : g_shift
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_dly <= '0;
                else       r_dly <= {r_dly[gr*ACT_WIDTH-1:0], w_inject[gr*ACT_WIDTH +: ACT_WIDTH]};
            end
        end

        assign a_row[gr*ACT_WIDTH +: ACT_WIDTH] = r_dly[(gr+1)*ACT_WIDTH-1 -: ACT_WIDTH];
    end

`ifdef ACT_SKEW_FEEDER_COUNT_EN
    logic [15:0] r_vec_count;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         r_vec_count <= 16'd0;
        else if (r_state == S_IDLE && start) r_vec_count <= 16'd0;
        else if (w_accept)                 r_vec_count <= sat_inc16(r_vec_count);
    end

    assign vec_count = r_vec_count;
`endif

endmodule
